collision_scan: RTL

- Parametrised, sequential successor to the combinational player/enemy collision check.
- On each frame tick it snapshots the player position, facing direction and N_OBJ enemy positions, then tests one enemy per clock against the player's two-box hitbox (head + body, mirrored by direction).
- Reports a per-frame hit mask, the lowest hit index and a one-cycle hit pulse to the game-state controller.
- Sits between the sprite position controllers and the lives/game-over logic in the pclk domain.

---
 rtl/collision_pkg.sv | 22 ++
 rtl/box_overlap.sv | 20 ++
 rtl/collision_scan.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/collision_pkg.sv
// Shared constants for the collision scanner: facing direction, FSM encoding
// and default sprite geometry.
package collision_pkg;

    localparam logic LEFT  = 1'b0;
    localparam logic RIGHT = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_REPORT = 2'd2
    } state_t;

    localparam int DEF_PLAYER_W = 16;
    localparam int DEF_HEAD_W   = 13;
    localparam int DEF_HEAD_H   = 13;
    localparam int DEF_BODY_W   = 7;
    localparam int DEF_BODY_H   = 5;
    localparam int DEF_OBJ_W    = 13;
    localparam int DEF_OBJ_H    = 13;

endpackage

// File: rtl/box_overlap.sv
// Combinational overlap test of two axis-aligned boxes given as half-open
// intervals [x0,x1) x [y0,y1); touching edges do not count.
module box_overlap #(
    parameter int W = 11
) (
    input  logic [W-1:0] a_x0_i,
    input  logic [W-1:0] a_x1_i,
    input  logic [W-1:0] a_y0_i,
    input  logic [W-1:0] a_y1_i,
    input  logic [W-1:0] b_x0_i,
    input  logic [W-1:0] b_x1_i,
    input  logic [W-1:0] b_y0_i,
    input  logic [W-1:0] b_y1_i,
    output logic         overlap_o
);

    assign overlap_o = (a_x0_i < b_x1_i) && (b_x0_i < a_x1_i) &&
                       (a_y0_i < b_y1_i) && (b_y0_i < a_y1_i);

endmodule

// File: rtl/collision_scan.sv
// Sequential player/enemy collision scanner: one enemy per clock after each
// frame tick. Define COLLISION_COOLDOWN_EN for post-hit suppression and the cooldown output.
module collision_scan
    import collision_pkg::*;
#(
    parameter int N_OBJ    = 3,
    parameter int XW       = 10,
    parameter int PLAYER_W = DEF_PLAYER_W,
    parameter int HEAD_W   = DEF_HEAD_W,
    parameter int HEAD_H   = DEF_HEAD_H,
    parameter int BODY_W   = DEF_BODY_W,
    parameter int BODY_H   = DEF_BODY_H,
    parameter int OBJ_W    = DEF_OBJ_W,
    parameter int OBJ_H    = DEF_OBJ_H
`ifdef COLLISION_COOLDOWN_EN
    , parameter int COOLDOWN_FRAMES = 60
`endif
) (
    input  logic                                  pclk,
    input  logic                                  rst,
    input  logic                                  frame_tick,
    input  logic                                  direction,
    input  logic [XW-1:0]                         player_x,
    input  logic [XW-1:0]                         player_y,
    input  logic [N_OBJ*XW-1:0]                   obj_x,
    input  logic [N_OBJ*XW-1:0]                   obj_y,
    input  logic [N_OBJ-1:0]                      obj_valid,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  hit,
    output logic [((N_OBJ>1)?$clog2(N_OBJ):1)-1:0] hit_id,
    output logic [N_OBJ-1:0]                      hit_mask
`ifdef COLLISION_COOLDOWN_EN
    , output logic                                cooldown
`endif
);

    localparam int IDW = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;
    localparam int CW  = XW + 1;
    localparam logic [IDW-1:0] LAST_IDX = IDW'(N_OBJ - 1);

    state_t               state_q, state_d;
    logic [IDW-1:0]       idx_q;
    logic                 dir_q;
    logic [XW-1:0]        px_q, py_q;
    logic [N_OBJ*XW-1:0]  ox_q, oy_q;
    logic [N_OBJ-1:0]     valid_q, acc_q, acc_d, mask_q;
    logic [IDW-1:0]       id_q;
    logic                 accept, last, head_ov, body_ov, coll_now;

    logic [CW-1:0] px, py, ox, oy;
    logic [CW-1:0] hx0, hx1, hy0, hy1, bx0, bx1, by0, by1, ex1, ey1;

    function automatic logic [IDW-1:0] lowest_set(input logic [N_OBJ-1:0] m);
        lowest_set = '0;
        for (int i = N_OBJ - 1; i >= 0; i--) begin
            if (m[i]) lowest_set = IDW'(i);
        end
    endfunction

    assign accept = (state_q == ST_IDLE) && frame_tick;
    assign last   = (state_q == ST_SCAN) && (idx_q == LAST_IDX);

    // Hitbox geometry at XW+1 bits so boxes near the right/bottom edge never wrap
    always_comb begin
        px  = CW'(px_q);
        py  = CW'(py_q);
        ox  = CW'(ox_q[int'(idx_q)*XW +: XW]);
        oy  = CW'(oy_q[int'(idx_q)*XW +: XW]);
        ex1 = ox + CW'(OBJ_W);
        ey1 = oy + CW'(OBJ_H);
        hy0 = py;
        hy1 = py + CW'(HEAD_H);
        by0 = py + CW'(HEAD_H);
        by1 = py + CW'(HEAD_H + BODY_H);
        if (dir_q == LEFT) begin
            hx0 = px;
            hx1 = px + CW'(HEAD_W);
            bx0 = px + CW'(PLAYER_W - BODY_W);
            bx1 = px + CW'(PLAYER_W);
        end else begin
            hx0 = px + CW'(PLAYER_W - HEAD_W);
            hx1 = px + CW'(PLAYER_W);
            bx0 = px;
            bx1 = px + CW'(BODY_W);
        end
    end

    box_overlap #(.W(CW)) u_head (
        .a_x0_i(hx0), .a_x1_i(hx1), .a_y0_i(hy0), .a_y1_i(hy1),
        .b_x0_i(ox),  .b_x1_i(ex1), .b_y0_i(oy),  .b_y1_i(ey1),
        .overlap_o(head_ov)
    );

    box_overlap #(.W(CW)) u_body (
        .a_x0_i(bx0), .a_x1_i(bx1), .a_y0_i(by0), .a_y1_i(by1),
        .b_x0_i(ox),  .b_x1_i(ex1), .b_y0_i(oy),  .b_y1_i(ey1),
        .overlap_o(body_ov)
    );

    assign coll_now = valid_q[idx_q] && (head_ov || body_ov);
    assign acc_d    = acc_q | (N_OBJ'(coll_now) << idx_q);

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (frame_tick) state_d = ST_SCAN;
            ST_SCAN:   if (idx_q == LAST_IDX) state_d = ST_REPORT;
            ST_REPORT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Result registers load on the last scan edge so they are valid alongside done
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            idx_q   <= '0;
            dir_q   <= 1'b0;
            px_q    <= '0;
            py_q    <= '0;
            ox_q    <= '0;
            oy_q    <= '0;
            valid_q <= '0;
            acc_q   <= '0;
            mask_q  <= '0;
            id_q    <= '0;
        end else if (accept) begin
            idx_q   <= '0;
            dir_q   <= direction;
            px_q    <= player_x;
            py_q    <= player_y;
            ox_q    <= obj_x;
            oy_q    <= obj_y;
            valid_q <= obj_valid;
            acc_q   <= '0;
        end else if (state_q == ST_SCAN) begin
            acc_q <= acc_d;
            if (last) begin
                mask_q <= acc_d;
                id_q   <= lowest_set(acc_d);
            end else begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

`ifdef COLLISION_COOLDOWN_EN
    localparam int CDW = $clog2(COOLDOWN_FRAMES + 1);
    logic [CDW-1:0] cd_q;
    logic           supp_q;

    // Suppression is decided per frame at its tick; only an unsuppressed hit reloads
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            cd_q   <= '0;
            supp_q <= 1'b0;
        end else if (accept) begin
            supp_q <= (cd_q != '0);
            if (cd_q != '0) cd_q <= cd_q - 1'b1;
        end else if (last && (|acc_d) && !supp_q) begin
            cd_q <= CDW'(COOLDOWN_FRAMES);
        end
    end

    assign cooldown = (cd_q != '0);
`endif

    always_comb begin
        busy = (state_q == ST_SCAN);
        done = (state_q == ST_REPORT);
`ifdef COLLISION_COOLDOWN_EN
        hit  = done && (|mask_q) && !supp_q;
`else
        hit  = done && (|mask_q);
`endif
    end

    assign hit_mask = mask_q;
    assign hit_id   = id_q;

endmodule
